// File: rtl/reg_select_decoder.sv
// 5-to-32 register-select decoder with a debug scan sequencer that walks the
// bus-drive enable across every register, one beat per accepted handshake.
module reg_select_decoder #(
    parameter int SEL_W    = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [SEL_W-1:0]    ra,
    input  logic [SEL_W-1:0]    rb,
    input  logic [SEL_W-1:0]    rc,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                scan_start,
    input  logic                scan_ready,
    output logic [NUM_REGS-1:0] r_in_en,
    output logic [NUM_REGS-1:0] r_out_en,
    output logic [SEL_W-1:0]    sel_code,
    output logic                sel_err,
    output logic                scan_busy,
    output logic                scan_valid,
    output logic                scan_done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);
    localparam logic [SEL_W-1:0]    LAST = SEL_W'(NUM_REGS - 1);

    state_t              r_state;
    logic [SEL_W-1:0]    r_cnt;

    logic [SEL_W-1:0]    w_code;
    logic                w_any;
    logic                w_multi;
    logic                w_in_range;
    logic                w_err;
    logic [NUM_REGS-1:0] w_onehot;
    logic [SEL_W-1:0]    w_next_cnt;

    // Priority select gra > grb > grc; an unselected decode yields code 0.
    always_comb begin
        w_code = '0;
        if (gra)      w_code = ra;
        else if (grb) w_code = rb;
        else if (grc) w_code = rc;
        w_any      = gra | grb | grc;
        w_multi    = (gra & grb) | (gra & grc) | (grb & grc);
        w_in_range = (32'(w_code) < NUM_REGS);
        w_onehot   = (w_any && w_in_range) ? (ONE << w_code) : '0;
        w_err      = w_multi | (w_any & ~w_in_range);
        w_next_cnt = r_cnt + SEL_W'(1);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_in_en    <= '0;
            r_out_en   <= '0;
            sel_code   <= '0;
            sel_err    <= 1'b0;
            scan_busy  <= 1'b0;
            scan_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            case (r_state)
                S_SCAN: begin
                    if (scan_valid && scan_ready) begin
                        if (r_cnt == LAST) begin
                            r_state    <= S_DONE;
                            r_cnt      <= '0;
                            r_in_en    <= '0;
                            r_out_en   <= '0;
                            sel_code   <= '0;
                            sel_err    <= 1'b0;
                            scan_busy  <= 1'b0;
                            scan_valid <= 1'b0;
                            scan_done  <= 1'b1;
                        end else begin
                            r_cnt    <= w_next_cnt;
                            r_out_en <= ONE << w_next_cnt;
                            sel_code <= w_next_cnt;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    // scan_start only counts in IDLE; leaving DONE always decodes.
                    if (r_state == S_IDLE && scan_start) begin
                        r_state    <= S_SCAN;
                        r_cnt      <= '0;
                        r_in_en    <= '0;
                        r_out_en   <= ONE;
                        sel_code   <= '0;
                        sel_err    <= 1'b0;
                        scan_busy  <= 1'b1;
                        scan_valid <= 1'b1;
                        scan_done  <= 1'b0;
                    end else begin
                        r_state    <= S_IDLE;
                        r_in_en    <= rin  ? w_onehot : '0;
                        r_out_en   <= rout ? w_onehot : '0;
                        sel_code   <= w_any ? w_code : '0;
                        sel_err    <= w_err;
                        scan_busy  <= 1'b0;
                        scan_valid <= 1'b0;
                        scan_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
